// File: rtl/mem_wb_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_multi_pkg
// Description : Shared constants, update-action encoding and popcount helper
//               for the multi-lane MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_multi_pkg;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  typedef enum logic [2:0] {
    ACT_FLUSH   = 3'd0,
    ACT_BUBBLE  = 3'd1,
    ACT_CAPTURE = 3'd2,
    ACT_HOLD    = 3'd3
  } upd_action_t;

  // Lane count never exceeds four, so callers zero-extend into this width.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_multi_waw_filter.sv
`default_nettype none
// ============================================================================
// Module      : wb_waw_filter
// Description : Combinational write-enable sanitiser with same-bundle WAW
//               resolution; the highest lane writing an address wins.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_waw_filter #(
  parameter int LANES         = 2,
  parameter int ADDR_W        = 5,
  parameter int SEL_W         = 4,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic [LANES-1:0]        valid,
  input  logic [LANES-1:0]        we,
  input  logic [LANES*ADDR_W-1:0] waddr,
  input  logic [LANES*SEL_W-1:0]  wsel,
  output logic [LANES-1:0]        eff_we
);

  logic [LANES-1:0] w_base;

  always_comb begin
    w_base = '0;
    for (int i = 0; i < LANES; i++) begin
      w_base[i] = valid[i] && we[i] && (|wsel[i*SEL_W +: SEL_W]) &&
                  !((ZERO_SUPPRESS != 0) && (waddr[i*ADDR_W +: ADDR_W] == '0));
    end
  end

  // A lower lane loses only to a higher lane that would itself really write.
  always_comb begin
    eff_we = w_base;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (w_base[i] && w_base[j] &&
            (waddr[i*ADDR_W +: ADDR_W] == waddr[j*ADDR_W +: ADDR_W])) begin
          eff_we[i] = 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_multi.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_multi
// Description : Multi-lane MEM/WB pipeline register with stall/bubble, flush,
//               sanitised write enables and a wrapping retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_multi
  import mem_wb_multi_pkg::*;
#(
  parameter int LANES         = 2,
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int STALL_W       = 6,
  parameter int STAGE         = 4,
  parameter int CNT_W         = 32,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [STALL_W-1:0]            stall,
  input  logic                          flush,
  input  logic [LANES-1:0]              mem_valid_i,
  input  logic [LANES*ADDR_W-1:0]       mem_waddr_i,
  input  logic [LANES-1:0]              mem_we_i,
  input  logic [LANES*DATA_W-1:0]       mem_wdata_i,
  input  logic [LANES*(DATA_W/8)-1:0]   mem_wsel_i,
  output logic [LANES-1:0]              wb_valid_o,
  output logic [LANES*ADDR_W-1:0]       wb_waddr_o,
  output logic [LANES-1:0]              wb_we_o,
  output logic [LANES*DATA_W-1:0]       wb_wdata_o,
  output logic [LANES*(DATA_W/8)-1:0]   wb_wsel_o,
  output logic [CNT_W-1:0]              retire_cnt_o
);

  localparam int c_SEL_W = DATA_W / 8;

  logic [LANES-1:0]         w_eff_we;
  logic [3:0]               w_valid4;
  logic [2:0]               w_pop;
  upd_action_t              w_action;

  logic [LANES-1:0]         r_valid;
  logic [LANES*ADDR_W-1:0]  r_waddr;
  logic [LANES-1:0]         r_we;
  logic [LANES*DATA_W-1:0]  r_wdata;
  logic [LANES*c_SEL_W-1:0] r_wsel;
  logic [CNT_W-1:0]         r_cnt;

  wb_waw_filter #(
    .LANES         (LANES),
    .ADDR_W        (ADDR_W),
    .SEL_W         (c_SEL_W),
    .ZERO_SUPPRESS (ZERO_SUPPRESS)
  ) u_waw_filter (
    .valid  (mem_valid_i),
    .we     (mem_we_i),
    .waddr  (mem_waddr_i),
    .wsel   (mem_wsel_i),
    .eff_we (w_eff_we)
  );

  assign w_valid4 = 4'(mem_valid_i);
  assign w_pop    = popcount4(w_valid4);

  // Flush outranks every stall combination; bubble only when WB can advance.
  always_comb begin
    w_action = ACT_HOLD;
    if (flush) begin
      w_action = ACT_FLUSH;
    end else if (stall[STAGE] == STOP && stall[STAGE+1] == NO_STOP) begin
      w_action = ACT_BUBBLE;
    end else if (stall[STAGE] == NO_STOP) begin
      w_action = ACT_CAPTURE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_valid <= '0;
      r_waddr <= '0;
      r_we    <= '0;
      r_wdata <= '0;
      r_wsel  <= '0;
      r_cnt   <= '0;
    end else begin
      case (w_action)
        ACT_FLUSH, ACT_BUBBLE: begin
          r_valid <= '0;
          r_waddr <= '0;
          r_we    <= '0;
          r_wdata <= '0;
          r_wsel  <= '0;
        end
        ACT_CAPTURE: begin
          r_valid <= mem_valid_i;
          r_waddr <= mem_waddr_i;
          r_we    <= w_eff_we;
          r_wdata <= mem_wdata_i;
          r_wsel  <= mem_wsel_i;
          r_cnt   <= r_cnt + CNT_W'(w_pop);
        end
        default: ;
      endcase
    end
  end

  assign wb_valid_o   = r_valid;
  assign wb_waddr_o   = r_waddr;
  assign wb_we_o      = r_we;
  assign wb_wdata_o   = r_wdata;
  assign wb_wsel_o    = r_wsel;
  assign retire_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_multi
// Description : Directed plus randomised bench for mem_wb_multi (2 lanes,
//               4-bit retire counter) against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [1:0]  mem_valid_i;
  logic [9:0]  mem_waddr_i;
  logic [1:0]  mem_we_i;
  logic [63:0] mem_wdata_i;
  logic [7:0]  mem_wsel_i;
  logic [1:0]  wb_valid_o;
  logic [9:0]  wb_waddr_o;
  logic [1:0]  wb_we_o;
  logic [63:0] wb_wdata_o;
  logic [7:0]  wb_wsel_o;
  logic [3:0]  retire_cnt_o;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [1:0]  m_valid;
  logic [9:0]  m_waddr;
  logic [1:0]  m_we;
  logic [63:0] m_wdata;
  logic [7:0]  m_wsel;
  int          m_retired;

  always #5 clk = ~clk;

  mem_wb_multi #(
    .LANES(2), .DATA_W(32), .ADDR_W(5), .STALL_W(6),
    .STAGE(4), .CNT_W(4), .ZERO_SUPPRESS(1)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid_i(mem_valid_i), .mem_waddr_i(mem_waddr_i),
    .mem_we_i(mem_we_i), .mem_wdata_i(mem_wdata_i), .mem_wsel_i(mem_wsel_i),
    .wb_valid_o(wb_valid_o), .wb_waddr_o(wb_waddr_o), .wb_we_o(wb_we_o),
    .wb_wdata_o(wb_wdata_o), .wb_wsel_o(wb_wsel_o), .retire_cnt_o(retire_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Which lanes actually write: a lane writes if it is a real, enabled,
  // non-empty, non-r0 write and no higher lane writes the same register.
  function automatic logic [1:0] writers(input logic [1:0] v, input logic [9:0] a,
                                         input logic [1:0] w, input logic [7:0] s);
    logic [1:0] want;
    logic [1:0] res;
    for (int i = 0; i < 2; i++)
      want[i] = v[i] && w[i] && (s[i*4 +: 4] != 4'd0) && (a[i*5 +: 5] != 5'd0);
    res = want;
    if (want[1] && want[0] && a[4:0] == a[9:5]) res[0] = 1'b0;
    return res;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_valid = '0; m_waddr = '0; m_we = '0; m_wdata = '0; m_wsel = '0;
      m_retired = 0;
    end else if (flush || (stall[4] && !stall[5])) begin
      m_valid = '0; m_waddr = '0; m_we = '0; m_wdata = '0; m_wsel = '0;
    end else if (!stall[4]) begin
      m_valid   = mem_valid_i;
      m_waddr   = mem_waddr_i;
      m_we      = writers(mem_valid_i, mem_waddr_i, mem_we_i, mem_wsel_i);
      m_wdata   = mem_wdata_i;
      m_wsel    = mem_wsel_i;
      m_retired = m_retired + int'(mem_valid_i[0]) + int'(mem_valid_i[1]);
    end
  endtask

  task automatic check_all();
    chk("valid", 64'(wb_valid_o), 64'(m_valid));
    chk("waddr", 64'(wb_waddr_o), 64'(m_waddr));
    chk("we",    64'(wb_we_o),    64'(m_we));
    chk("wdata", wb_wdata_o,      m_wdata);
    chk("wsel",  64'(wb_wsel_o),  64'(m_wsel));
    chk("cnt",   64'(retire_cnt_o), 64'(m_retired % 16));
  endtask

  task automatic cyc(input logic r, input logic [5:0] st, input logic f,
                     input logic [1:0] v, input logic [9:0] a, input logic [1:0] w,
                     input logic [63:0] d, input logic [7:0] s);
    rst = r; stall = st; flush = f;
    mem_valid_i = v; mem_waddr_i = a; mem_we_i = w; mem_wdata_i = d; mem_wsel_i = s;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rnd_cyc(input logic r, input logic [5:0] st, input logic f);
    logic [7:0] s;
    s[3:0] = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
    s[7:4] = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
    cyc(r, st, f, 2'($urandom), {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
        2'($urandom), {$urandom, $urandom}, s);
  endtask

  initial begin
    m_valid = '0; m_waddr = '0; m_we = '0; m_wdata = '0; m_wsel = '0; m_retired = 0;
    rst = 1'b1; stall = '0; flush = 1'b0;
    mem_valid_i = '0; mem_waddr_i = '0; mem_we_i = '0; mem_wdata_i = '0; mem_wsel_i = '0;

    // Reset with random inputs, explicit zero checks
    rnd_cyc(1'b1, 6'($urandom), 1'($urandom));
    rnd_cyc(1'b1, 6'($urandom), 1'($urandom));
    chk("rst_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_cnt",   64'(retire_cnt_o), 64'd0);

    // Capture and count
    for (int k = 0; k < 3; k++)
      cyc(1'b0, 6'd0, 1'b0, 2'b11, {5'd3, 5'd7}, 2'b11,
          {32'hAAAA_0000 + 32'(k), 32'hBBBB_0000 + 32'(k)}, 8'hFF);
    chk("cnt_after_3", 64'(retire_cnt_o), 64'd6);

    // WAW, then zero-register suppression
    cyc(1'b0, 6'd0, 1'b0, 2'b11, {5'd9, 5'd9}, 2'b11, 64'h1111_2222_3333_4444, 8'hFF);
    chk("waw_we", 64'(wb_we_o), 64'h2);
    chk("waw_d1", 64'(wb_wdata_o[63:32]), 64'h1111_2222);
    cyc(1'b0, 6'd0, 1'b0, 2'b11, {5'd0, 5'd4}, 2'b11, 64'h5555_6666_7777_8888, 8'hFF);
    chk("zero_we", 64'(wb_we_o), 64'h1);

    // Full stall holds, bubble clears, then capture resumes
    for (int k = 0; k < 4; k++) rnd_cyc(1'b0, 6'b111111, 1'b0);
    chk("hold_data", wb_wdata_o, 64'h5555_6666_7777_8888);
    rnd_cyc(1'b0, 6'b011111, 1'b0);
    rnd_cyc(1'b0, 6'b011111, 1'b0);
    chk("bubble_valid", 64'(wb_valid_o), 64'd0);
    cyc(1'b0, 6'd0, 1'b0, 2'b01, {5'd1, 5'd2}, 2'b01, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F);

    // Flush under full stall
    cyc(1'b0, 6'd0, 1'b0, 2'b11, {5'd5, 5'd6}, 2'b11, 64'h0123_4567_89AB_CDEF, 8'hFF);
    rnd_cyc(1'b0, 6'b111111, 1'b1);
    chk("flush_data", wb_wdata_o, 64'd0);

    // Randomised traffic
    for (int k = 0; k < 300; k++) begin
      logic [5:0] st;
      case ($urandom_range(0, 5))
        0: st = 6'b111111;
        1: st = 6'b011111;
        2: st = 6'($urandom);
        default: st = 6'b000000;
      endcase
      rnd_cyc(($urandom_range(0, 60) == 0), st, ($urandom_range(0, 15) == 0));
    end

    // Counter wrap: 15 singles then a pair
    rnd_cyc(1'b1, 6'd0, 1'b0);
    for (int k = 0; k < 15; k++)
      cyc(1'b0, 6'd0, 1'b0, 2'b01, {5'd0, 5'd8}, 2'b01, 64'(k), 8'h01);
    chk("pre_wrap", 64'(retire_cnt_o), 64'd15);
    cyc(1'b0, 6'd0, 1'b0, 2'b11, {5'd10, 5'd11}, 2'b11, 64'h1, 8'hFF);
    chk("wrap", 64'(retire_cnt_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_multi.md
# mem_wb_multi

Parametrised, multi-lane successor to the single-lane MEM/WB pipeline register. It captures up to LANES write-back requests per cycle from the MEM stage and presents them to the register file. It honours the global stall vector and inserts a bubble when MEM stalls while WB proceeds. It adds a flush input, per-lane byte enables, same-bundle write-after-write (WAW) resolution, zero-register suppression and a retired-instruction counter.

## Interface

Parameters:
- LANES, 2, number of parallel write-back lanes (1..4)
- DATA_W, 32, register data width (multiple of 8)
- ADDR_W, 5, register address width
- STALL_W, 6, width of global stall vector
- STAGE, 4, index of this register's input stage in stall; STAGE+1 < STALL_W
- CNT_W, 32, retire counter width
- ZERO_SUPPRESS, 1, when 1 a write to register 0 has its we forced to 0

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset (`RstEnable`)
- stall  in  STALL_W  global stall vector; bit = `Stop` holds that stage
- flush  in  1  pipeline flush from ctrl
- mem_valid_i  in  LANES  lane carries a real instruction
- mem_waddr_i  in  LANES*ADDR_W  destination register per lane (lane 0 in LSBs)
- mem_we_i  in  LANES  write enable per lane
- mem_wdata_i  in  LANES*DATA_W  write data per lane
- mem_wsel_i  in  LANES*DATA_W/8  byte enables per lane
- wb_valid_o  out  LANES  registered valid
- wb_waddr_o  out  LANES*ADDR_W  registered destination
- wb_we_o  out  LANES  registered, sanitised write enable
- wb_wdata_o  out  LANES*DATA_W  registered data
- wb_wsel_o  out  LANES*DATA_W/8  registered byte enables
- retire_cnt_o  out  CNT_W  count of valid lanes retired through this register

## Operation

- Sanitising runs before capture and is purely combinational on the inputs, per lane i:
  - eff_we[i] = mem_we_i[i] & mem_valid_i[i].
  - eff_we[i] is also 0 when ZERO_SUPPRESS and waddr==0.
  - eff_we[i] is also 0 when wsel==0.
- WAW resolution: if lanes i<j both have eff_we set with equal waddr, lane i's eff_we is cleared. The highest lane wins; no byte merging. Valid is unaffected.
- Per-cycle update uses this priority, with exactly one action per edge:
  1. rst: all outputs go to 0, including retire_cnt_o.
  2. flush: all lane fields go to 0; retire_cnt_o holds.
  3. Bubble, when stall[STAGE]==`Stop` and stall[STAGE+1]==`NoStop`: all lane fields go to 0; counter holds.
  4. Capture, when stall[STAGE]==`NoStop`: lane fields are loaded with the sanitised inputs. retire_cnt_o += popcount(mem_valid_i).
  5. Otherwise (both stages stalled): everything holds.
- The counter wraps modulo 2^CNT_W with no saturation or overflow flag.
- Reset value of every output is 0.

## Timing

- Latency is one cycle: inputs sampled at edge n appear on wb_* after edge n.
- No combinational path from any input to any output.
- retire_cnt_o updates on the same edge as the capture it counts.
- Flush asserted together with any stall still clears the lane fields. The counter does not advance.
- Reset asserted mid-stall clears the register on that edge. The first capture can occur on the edge after rst deasserts.
- A bubble lasts one edge per cycle of the bubble condition. Repeated bubble cycles keep the outputs at 0.

## Structure

- The `defines.v` include supplies `RstEnable`, `Stop`, `NoStop`, `WriteEnable`, `WriteDisable` and `ZeroWord`. No new global constants are needed.
- One sub-module, wb_waw_filter, is combinational. Its inputs are the valid, we, waddr and wsel vectors; its output is the eff_we vector. It is parametrised on LANES, ADDR_W and DATA_W/8, and is reused by the register-file write arbiter.
- The top holds the lane registers, the priority mux and a popcount into the counter.

## Test plan

- Reset: drive rst=1 with random inputs for 2 cycles → all wb_* outputs = 0 and retire_cnt_o = 0; first capture after deassert appears one cycle later.
- Capture and count: LANES=2, each cycle drive valid=2'b11, waddr={5'd3,5'd7}, we=2'b11, wdata={A,B} for 3 cycles → outputs match one cycle later; retire_cnt_o = 6.
- WAW and zero-register suppression:
  - waddr={5'd9,5'd9}, we=2'b11 → wb_we_o=2'b10, data of lane 1 intact.
  - Next bundle waddr={5'd0,5'd4} → wb_we_o=2'b01.
- Stall semantics:
  - stall=6'b011111 → bubble, outputs 0, counter frozen.
  - stall=6'b111111 → prior contents held for 4 cycles.
  - stall=0 → capture resumes.
- Flush priority: flush=1 with stall=6'b111111 and nonzero contents → lane fields 0, retire_cnt_o unchanged.
- Counter wrap: CNT_W=4, preload by capturing 15 single-valid bundles, then a 2-valid bundle → retire_cnt_o = 1.
